// File: rtl/regfile_sb_pkg.sv
// Default widths and port counts shared by the scoreboarded register file and its scoreboard.
package regfile_sb_pkg;
   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_CNT_WIDTH  = 2;
   localparam int RF_NUM_RD     = 2;
   localparam int RF_NUM_WR     = 2;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: per-register claim counters, issue stall and read hazard flags.
// Counters update on posedge; iss_ready and rd_busy are combinational, sb_err is sticky until reset.
module rf_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int NUM_RD     = RF_NUM_RD,
   parameter int NUM_WR     = RF_NUM_WR,
   parameter int CNT_WIDTH  = RF_CNT_WIDTH,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                         i_iss_valid,
   input  logic                         i_iss_we,
   input  logic [ADDR_WIDTH-1:0]        i_iss_rd,
   input  logic [NUM_WR-1:0]            i_q,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wb_addr,
   output logic                         o_iss_ready,
   output logic [NUM_RD-1:0]            o_rd_busy,
   output logic                         o_sb_err
);
   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam int RW       = CNT_WIDTH + 1;

   logic [CNT_WIDTH-1:0] r_cnt [NUM_REGS];
   logic [NUM_REGS-1:0]  w_under;
   logic                 w_claim;
   logic                 r_err;

   // Number of qualified write ports retiring into register a this cycle.
   function automatic logic [RW-1:0] f_retire(input logic [NUM_WR-1:0]            q,
                                              input logic [NUM_WR*ADDR_WIDTH-1:0] wa,
                                              input logic [ADDR_WIDTH-1:0]        a);
      logic [RW-1:0] n;
      n = '0;
      for (int w = 0; w < NUM_WR; w++)
         if (q[w] && wa[w*ADDR_WIDTH +: ADDR_WIDTH] == a) n = n + RW'(1);
      return n;
   endfunction

   assign o_iss_ready = !(i_iss_we && r_cnt[i_iss_rd] == {CNT_WIDTH{1'b1}});
   assign w_claim     = i_iss_valid && i_iss_we && o_iss_ready && !(ZERO_REG && i_iss_rd == '0);

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
      logic [RW-1:0] w_ret;
      logic [RW-1:0] w_sum;
      assign w_ret      = f_retire(i_q, i_wb_addr, ADDR_WIDTH'(r));
      assign w_sum      = RW'(r_cnt[r]) + RW'(w_claim && i_iss_rd == ADDR_WIDTH'(r));
      assign w_under[r] = w_ret > RW'(r_cnt[r]);

      // An unmatched retire floors the counter at zero rather than wrapping.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)              r_cnt[r] <= '0;
         else if (w_ret > w_sum)  r_cnt[r] <= '0;
         else                     r_cnt[r] <= CNT_WIDTH'(w_sum - w_ret);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_err <= 1'b0;
      else if (|w_under)   r_err <= 1'b1;
   end
   assign o_sb_err = r_err;

   // A register retiring this cycle is not busy: its value arrives through the bypass.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
      logic [ADDR_WIDTH-1:0] w_ra;
      assign w_ra         = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign o_rd_busy[p] = !(ZERO_REG && w_ra == '0) &&
                            (RW'(r_cnt[w_ra]) > f_retire(i_q, i_wb_addr, w_ra));
   end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and pending-write scoreboard.
// Reads are zero-latency, writes land on posedge; issue stalls via iss_ready when a counter saturates.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int NUM_RD     = RF_NUM_RD,
   parameter int NUM_WR     = RF_NUM_WR,
   parameter int CNT_WIDTH  = RF_CNT_WIDTH,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic                         iss_valid,
   input  logic                         iss_we,
   input  logic [ADDR_WIDTH-1:0]        iss_rd,
   output logic                         iss_ready,
   input  logic [NUM_WR-1:0]            wb_we,
   input  logic [NUM_WR-1:0]            wb_valid,
   input  logic [NUM_WR-1:0]            wb_ready_go,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wb_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wb_data,
   output logic                         allow_in_regfile,
   output logic                         sb_err
);
   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_rf [NUM_REGS];
   logic [NUM_WR-1:0]     w_q;
   logic                  r_allow;

   for (genvar w = 0; w < NUM_WR; w++) begin : g_wq
      logic [ADDR_WIDTH-1:0] w_wa;
      assign w_wa   = wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_q[w] = wb_we[w] && wb_valid[w] && wb_ready_go[w] && !(ZERO_REG && w_wa == '0);
   end

   // Ports are applied in ascending order so the highest-index port wins a shared address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) r_rf[r] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++)
            if (w_q[w]) r_rf[wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wb_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_allow <= 1'b0;
      else        r_allow <= 1'b1;
   end
   assign allow_in_regfile = r_allow;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_val;
      assign w_ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      always_comb begin
         w_val = r_rf[w_ra];
         if (BYPASS)
            for (int w = 0; w < NUM_WR; w++)
               if (w_q[w] && wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)
                  w_val = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
         if (ZERO_REG && w_ra == '0) w_val = '0;
      end
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_val;
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_RD     (NUM_RD),
      .NUM_WR     (NUM_WR),
      .CNT_WIDTH  (CNT_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd_addr   (rd_addr),
      .i_iss_valid (iss_valid),
      .i_iss_we    (iss_we),
      .i_iss_rd    (iss_rd),
      .i_q         (w_q),
      .i_wb_addr   (wb_addr),
      .o_iss_ready (iss_ready),
      .o_rd_busy   (rd_busy),
      .o_sb_err    (sb_err)
   );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        iss_valid, iss_we, iss_ready;
   logic [4:0]  iss_rd;
   logic [1:0]  wb_we, wb_valid, wb_ready_go;
   logic [9:0]  wb_addr;
   logic [63:0] wb_data;
   logic        allow_in_regfile, sb_err;

   logic [4:0]  ra [2];
   logic [4:0]  wa [2];
   logic [31:0] wd [2];

   logic [31:0] m_rf  [32];
   int          m_cnt [32];
   bit          m_err;
   int          total = 0;
   int          bad   = 0;

   assign rd_addr = {ra[1], ra[0]};
   assign wb_addr = {wa[1], wa[0]};
   assign wb_data = {wd[1], wd[0]};

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .wb_we(wb_we), .wb_valid(wb_valid), .wb_ready_go(wb_ready_go), .wb_addr(wb_addr),
      .wb_data(wb_data), .allow_in_regfile(allow_in_regfile), .sb_err(sb_err)
   );

   // ---------------- behavioural model ----------------
   function automatic bit m_q(int w);
      return wb_we[w] && wb_valid[w] && wb_ready_go[w] && wa[w] != 5'd0;
   endfunction

   function automatic int m_ret(logic [4:0] a);
      int n = 0;
      for (int w = 0; w < 2; w++) if (m_q(w) && wa[w] == a) n++;
      return n;
   endfunction

   function automatic logic [31:0] m_rd(logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0) return 32'd0;
      v = m_rf[a];
      for (int w = 0; w < 2; w++) if (m_q(w) && wa[w] == a) v = wd[w];
      return v;
   endfunction

   function automatic bit m_busy(logic [4:0] a);
      return a != 5'd0 && (m_cnt[a] - m_ret(a)) > 0;
   endfunction

   function automatic bit m_ready();
      return !(iss_we && m_cnt[iss_rd] == 3);
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) begin m_rf[r] = 32'd0; m_cnt[r] = 0; end
      m_err = 1'b0;
   endtask

   task automatic tick();
      bit claim;
      int n;
      claim = iss_valid && iss_we && m_ready() && iss_rd != 5'd0;
      for (int r = 0; r < 32; r++) begin
         n = m_cnt[r] + ((claim && iss_rd == r) ? 1 : 0) - m_ret(5'(r));
         if (m_ret(5'(r)) > m_cnt[r]) m_err = 1'b1;
         m_cnt[r] = (n < 0) ? 0 : n;
      end
      for (int w = 0; w < 2; w++) if (m_q(w)) m_rf[wa[w]] = wd[w];
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      iss_valid = 0; iss_we = 0; iss_rd = 0;
      wb_we = 0; wb_valid = 0; wb_ready_go = 0;
      wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
   endtask

   task automatic wb(int w, logic [4:0] a, logic [31:0] d);
      wb_we[w] = 1; wb_valid[w] = 1; wb_ready_go[w] = 1; wa[w] = a; wd[w] = d;
   endtask

   task automatic claim(logic [4:0] a);
      iss_valid = 1; iss_we = 1; iss_rd = a;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle(); ra[0] = 5; ra[1] = 7; rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (allow_in_regfile !== 1'b0) begin bad++; $display("FAIL reset_allow: got %b want 0", allow_in_regfile); end
      total++; if (rd_data !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
      total++; if (rd_busy !== 2'b00 || sb_err !== 1'b0) begin bad++; $display("FAIL reset_busy_err: got busy=%b err=%b want 00/0", rd_busy, sb_err); end
      m_reset();
      rst_n = 1; #1;
      total++; if (allow_in_regfile !== 1'b0) begin bad++; $display("FAIL allow_before_edge: got %b want 0", allow_in_regfile); end
      @(posedge clk); #1;
      total++; if (allow_in_regfile !== 1'b1) begin bad++; $display("FAIL allow_after_edge: got %b want 1", allow_in_regfile); end
   endtask

   task automatic test_bypass();
      idle(); ra[0] = 5; ra[1] = 5; claim(5); tick();
      idle(); #1;
      total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL bypass_busy_pre: got %b want 1", rd_busy[0]); end
      wb(0, 5, 32'hDEADBEEF); #1;
      total++; if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_same: got %h want deadbeef", rd_data[31:0]); end
      total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass_busy_retire: got %b want 0", rd_busy[0]); end
      tick(); idle(); #1;
      total++; if (rd_data[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_array: got %h want deadbeef", rd_data[63:32]); end
   endtask

   task automatic test_same_addr();
      idle(); ra[0] = 7; ra[1] = 7;
      claim(7); tick(); claim(7); tick(); idle(); #1;
      total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL dual_busy_pre: got %b want 11", rd_busy); end
      wb(0, 7, 32'h11); wb(1, 7, 32'h22); #1;
      total++; if (rd_data[63:32] !== 32'h22) begin bad++; $display("FAIL dual_same: got %h want 22", rd_data[63:32]); end
      total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL dual_busy_retire: got %b want 00", rd_busy); end
      tick(); idle(); #1;
      total++; if (rd_data[31:0] !== 32'h22) begin bad++; $display("FAIL dual_next: got %h want 22", rd_data[31:0]); end
      total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL dual_err: got %b want 0", sb_err); end
   endtask

   task automatic test_zero_reg();
      idle(); ra[0] = 0; ra[1] = 0;
      wb(0, 0, 32'h1234); claim(0); #1;
      total++; if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0) begin bad++; $display("FAIL x0_same: got data=%h busy=%b want 0/0", rd_data[31:0], rd_busy[0]); end
      total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b want 1", iss_ready); end
      tick(); idle(); #1;
      total++; if (rd_data[63:32] !== 32'd0 || rd_busy !== 2'b00 || sb_err !== 1'b0) begin bad++; $display("FAIL x0_next: got data=%h busy=%b err=%b want 0/00/0", rd_data[63:32], rd_busy, sb_err); end
   endtask

   task automatic test_saturate();
      idle(); ra[0] = 3; ra[1] = 3;
      for (int i = 0; i < 3; i++) begin
         claim(3); #1;
         total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_%0d: got %b want 1", i, iss_ready); end
         tick();
      end
      claim(3); #1;
      total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL sat_full: got %b want 0", iss_ready); end
      tick();
      idle(); wb(0, 3, 32'h300); tick();
      idle(); wb(0, 3, 32'h301); claim(3); #1;
      total++; if (iss_ready !== 1'b1 || rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sat_net: got ready=%b busy=%b want 1/1", iss_ready, rd_busy[0]); end
      tick(); idle(); claim(3); tick();
      claim(3); #1;
      total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL sat_refull: got %b want 0", iss_ready); end
      idle(); tick();
      for (int i = 0; i < 3; i++) begin
         idle(); wb(1, 3, 32'h310 + i); #1;
         total++; if (rd_busy[1] !== (i < 2)) begin bad++; $display("FAIL sat_drain_%0d: got %b want %b", i, rd_busy[1], i < 2); end
         tick();
      end
      idle(); #1;
      total++; if (rd_busy !== 2'b00 || sb_err !== 1'b0 || rd_data[31:0] !== 32'h312) begin bad++; $display("FAIL sat_end: got busy=%b err=%b data=%h want 00/0/312", rd_busy, sb_err, rd_data[31:0]); end
   endtask

   task automatic test_sb_err();
      idle(); ra[0] = 9; ra[1] = 9; wb(1, 9, 32'h99); #1;
      total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", sb_err); end
      tick(); idle(); #1;
      total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", sb_err); end
      total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL err_busy: got %b want 0", rd_busy[0]); end
      repeat (3) tick();
      total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", sb_err); end
   endtask

   task automatic test_random();
      int used [32];
      int r;
      int k;
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int i = 0; i < 32; i++) used[i] = 0;
         ra[0] = 5'($urandom_range(0, 7)); ra[1] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            iss_valid = ($urandom_range(0, 3) != 0);
            iss_we    = ($urandom_range(0, 3) != 0);
            iss_rd    = 5'($urandom_range(0, 7));
         end
         for (int w = 0; w < 2; w++) begin
            r = $urandom_range(0, 7);
            if (r == 0 || (m_cnt[r] > used[r] && $urandom_range(0, 2) != 0)) begin
               wb(w, 5'(r), $urandom);
               if (r != 0) used[r]++;
            end else if ($urandom_range(0, 1) == 1) begin
               wb(w, 5'(r), $urandom);
               k = $urandom_range(0, 2);
               if (k == 0) wb_we[w] = 0; else if (k == 1) wb_valid[w] = 0; else wb_ready_go[w] = 0;
            end
         end
         #1;
         for (int p = 0; p < 2; p++) begin
            total++; if (rd_data[p*32 +: 32] !== m_rd(ra[p])) begin bad++; $display("FAIL rnd_data c=%0d p=%0d: got %h want %h", c, p, rd_data[p*32 +: 32], m_rd(ra[p])); end
            total++; if (rd_busy[p] !== m_busy(ra[p])) begin bad++; $display("FAIL rnd_busy c=%0d p=%0d: got %b want %b", c, p, rd_busy[p], m_busy(ra[p])); end
         end
         total++; if (iss_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, iss_ready, m_ready()); end
         total++; if (sb_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, sb_err, m_err); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      idle(); ra[0] = 3; ra[1] = 5;
      wb(0, 5, 32'hCAFE0005); claim(3); tick();
      idle(); claim(3); tick();
      idle(); #1;
      total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %b want 1", rd_busy[0]); end
      rst_n = 0; #1;
      total++; if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin bad++; $display("FAIL mid_reset: got data=%h busy=%b want 0/00", rd_data, rd_busy); end
      total++; if (allow_in_regfile !== 1'b0 || sb_err !== 1'b0) begin bad++; $display("FAIL mid_allow_err: got allow=%b err=%b want 0/0", allow_in_regfile, sb_err); end
      m_reset();
      @(posedge clk); #1;
      rst_n = 1; #1;
      total++; if (allow_in_regfile !== 1'b0) begin bad++; $display("FAIL mid_allow_pre: got %b want 0", allow_in_regfile); end
      @(posedge clk); #1;
      total++; if (allow_in_regfile !== 1'b1 || rd_busy !== 2'b00) begin bad++; $display("FAIL mid_after: got allow=%b busy=%b want 1/00", allow_in_regfile, rd_busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      idle(); ra[0] = 0; ra[1] = 0;
      m_reset();
      test_reset();
      test_bypass();
      test_same_addr();
      test_zero_reg();
      test_saturate();
      test_sb_err();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
